// File: rtl/ysyx_25040129_idu_stage_pkg.sv
// ysyx_25040129_idu_stage_pkg
// Shared decode constants for the IDU stage. It holds the RV32 major opcodes,
// the ALU opcode encodings, the LSU read/write codes, the bit positions inside
// out_ctrl, and the immediate-extraction helpers.
// This file has no ports. Import it with: import ysyx_25040129_idu_stage_pkg::*;
package ysyx_25040129_idu_stage_pkg;

    // RV32 major opcodes (inst[6:0])
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Fixed SYSTEM encodings
    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    // ALU opcodes. Branch compares have their own codes, so the EXU knows
    // which condition to evaluate without seeing funct3.
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_BEQ  = 4'd10;
    localparam logic [3:0] ALU_BNE  = 4'd11;
    localparam logic [3:0] ALU_BLT  = 4'd12;
    localparam logic [3:0] ALU_BGE  = 4'd13;
    localparam logic [3:0] ALU_BLTU = 4'd14;
    localparam logic [3:0] ALU_BGEU = 4'd15;

    // LSU codes
    localparam logic [2:0] NO_MEM_READ   = 3'd0;
    localparam logic [2:0] MEM_READ_B    = 3'd1;
    localparam logic [2:0] MEM_READ_H    = 3'd2;
    localparam logic [2:0] MEM_READ_W    = 3'd3;
    localparam logic [2:0] MEM_READ_BU   = 3'd4;
    localparam logic [2:0] MEM_READ_HU   = 3'd5;
    localparam logic [1:0] NO_MEM_WRITE  = 2'd0;
    localparam logic [1:0] MEM_WRITE_B   = 2'd1;
    localparam logic [1:0] MEM_WRITE_H   = 2'd2;
    localparam logic [1:0] MEM_WRITE_W   = 2'd3;

    // out_ctrl bit indices
    localparam int CTRL_REG_WR  = 0;
    localparam int CTRL_CSR_WR  = 1;
    localparam int CTRL_JUMP    = 2;
    localparam int CTRL_JALR    = 3;
    localparam int CTRL_MRET    = 4;
    localparam int CTRL_ECALL   = 5;
    localparam int CTRL_EBREAK  = 6;
    localparam int CTRL_ILLEGAL = 7;

    // Immediate extraction, sign-extended to 32 bits
    function automatic logic [31:0] imm_i(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:25], inst[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] inst);
        return {inst[31:12], 12'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/ysyx_25040129_idu_stage_fwd_sel.sv
// ysyx_25040129_fwd_sel
// Resolves one source operand against the forwarding ports. Port 0 is the
// youngest producer and has the highest priority.
// Ports:
//   addr      in   source register address
//   rdata     in   register-file read data for addr
//   fwd_pend  in   per-port pending-write flags
//   fwd_rd    in   per-port destination registers, packed as RA_W bits per port
//   fwd_ok    in   per-port result-available flags
//   fwd_data  in   per-port results, packed as XLEN bits per port
//   value     out  resolved operand value
//   hazard    out  the youngest matching producer has no result yet
module ysyx_25040129_fwd_sel #(
    parameter int XLEN    = 32,
    parameter int RA_W    = 4,
    parameter int NUM_FWD = 3
) (
    input  logic [RA_W-1:0]         addr,
    input  logic [XLEN-1:0]         rdata,
    input  logic [NUM_FWD-1:0]      fwd_pend,
    input  logic [NUM_FWD*RA_W-1:0] fwd_rd,
    input  logic [NUM_FWD-1:0]      fwd_ok,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data,
    output logic [XLEN-1:0]         value,
    output logic                    hazard
);

    // The scan runs from oldest to youngest, so a later (younger) match
    // overwrites an earlier one and only the highest-priority match remains.
    // x0 is hard-wired to zero and never matches anything.
    always_comb begin
        value  = rdata;
        hazard = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_pend[i] && (fwd_rd[i*RA_W +: RA_W] == addr)) begin
                value  = fwd_ok[i] ? fwd_data[i*XLEN +: XLEN] : rdata;
                hazard = !fwd_ok[i];
            end
        end
        if (addr == '0) begin
            value  = '0;
            hazard = 1'b0;
        end
    end

endmodule

// File: rtl/ysyx_25040129_idu_stage.sv
// ysyx_25040129_idu_stage
// Registered decode stage between the IFU and the EXU. It decodes the
// instruction, resolves its operands through forwarding, stalls on
// unresolved RAW hazards, and holds the bundle in an ID/EX register with a
// valid/ready handshake and a flush input.
// Ports:
//   clock, reset              clock and synchronous active-high reset
//   in_valid/in_ready         IFU handshake; in_inst and in_pc are the instruction
//   rs1_addr/rs2_addr         GPR read addresses; rs1_rdata/rs2_rdata are the same-cycle data
//   fwd_pend/rd/ok/data       forwarding ports, index 0 = youngest
//   flush                     kills the held and the incoming instruction
//   out_valid/out_ready       EXU handshake
//   out_pc/src1/src2/imm/rd   decoded operands
//   out_alu_op/ctrl/lsu_rd/lsu_wr  decoded control
// Optional feature: YSYX_25040129_IDU_PERF_EN adds perf_issue and perf_stall.
// Operand convention: src1 is rs1 (PC for JAL/AUIPC, 0 otherwise); src2 is
// rs2 when rs2 is used (OP/STORE/BRANCH), otherwise the immediate.
module ysyx_25040129_idu_stage
    import ysyx_25040129_idu_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RA_W    = 4,
    parameter int NUM_FWD = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_inst,
    input  logic [XLEN-1:0]         in_pc,
    output logic [RA_W-1:0]         rs1_addr,
    output logic [RA_W-1:0]         rs2_addr,
    input  logic [XLEN-1:0]         rs1_rdata,
    input  logic [XLEN-1:0]         rs2_rdata,
    input  logic [NUM_FWD-1:0]      fwd_pend,
    input  logic [NUM_FWD*RA_W-1:0] fwd_rd,
    input  logic [NUM_FWD-1:0]      fwd_ok,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_pc,
    output logic [XLEN-1:0]         out_src1,
    output logic [XLEN-1:0]         out_src2,
    output logic [XLEN-1:0]         out_imm,
    output logic [RA_W-1:0]         out_rd,
    output logic [3:0]              out_alu_op,
    output logic [7:0]              out_ctrl,
    output logic [2:0]              out_lsu_rd,
    output logic [1:0]              out_lsu_wr
`ifdef YSYX_25040129_IDU_PERF_EN
    ,
    output logic [31:0]             perf_issue,
    output logic [31:0]             perf_stall
`endif
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [3:0]      alu_op;
    logic [7:0]      ctrl;
    logic [2:0]      lsu_rd;
    logic [1:0]      lsu_wr;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_x;
    logic            use_rs1;
    logic            use_rs2;
    logic            src1_pc;
    logic            illegal;
    logic [XLEN-1:0] val1;
    logic [XLEN-1:0] val2;
    logic            haz1;
    logic            haz2;
    logic            hazard;
    logic            capture;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;

    assign opcode   = in_inst[6:0];
    assign funct3   = in_inst[14:12];
    assign funct7   = in_inst[31:25];
    assign rs1_addr = in_inst[15 +: RA_W];
    assign rs2_addr = in_inst[20 +: RA_W];

    // Combinational decode. An unrecognised encoding keeps only the illegal
    // bit and still flows down the pipe, so the EXU can raise the exception.
    always_comb begin
        alu_op  = ALU_ADD;
        ctrl    = '0;
        lsu_rd  = NO_MEM_READ;
        lsu_wr  = NO_MEM_WRITE;
        imm32   = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        src1_pc = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                use_rs1 = 1'b1;
                imm32   = imm_i(in_inst);
                ctrl[CTRL_REG_WR] = 1'b1;
                case (funct3)
                    3'd0: alu_op = ALU_ADD;
                    3'd1: begin alu_op = ALU_SLL; illegal = (funct7 != 7'd0); end
                    3'd2: alu_op = ALU_SLT;
                    3'd3: alu_op = ALU_SLTU;
                    3'd4: alu_op = ALU_XOR;
                    3'd5: begin
                        alu_op  = funct7[5] ? ALU_SRA : ALU_SRL;
                        illegal = ((funct7 & 7'b1011111) != 7'd0);
                    end
                    3'd6: alu_op = ALU_OR;
                    default: alu_op = ALU_AND;
                endcase
            end
            OPC_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                ctrl[CTRL_REG_WR] = 1'b1;
                // Only ADD/SUB and SRL/SRA may set funct7[5]
                if ((funct3 == 3'd0) || (funct3 == 3'd5))
                    illegal = ((funct7 & 7'b1011111) != 7'd0);
                else
                    illegal = (funct7 != 7'd0);
                case (funct3)
                    3'd0: alu_op = funct7[5] ? ALU_SUB : ALU_ADD;
                    3'd1: alu_op = ALU_SLL;
                    3'd2: alu_op = ALU_SLT;
                    3'd3: alu_op = ALU_SLTU;
                    3'd4: alu_op = ALU_XOR;
                    3'd5: alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'd6: alu_op = ALU_OR;
                    default: alu_op = ALU_AND;
                endcase
            end
            OPC_LOAD: begin
                use_rs1 = 1'b1;
                imm32   = imm_i(in_inst);
                ctrl[CTRL_REG_WR] = 1'b1;
                case (funct3)
                    3'd0: lsu_rd = MEM_READ_B;
                    3'd1: lsu_rd = MEM_READ_H;
                    3'd2: lsu_rd = MEM_READ_W;
                    3'd4: lsu_rd = MEM_READ_BU;
                    3'd5: lsu_rd = MEM_READ_HU;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm32   = imm_s(in_inst);
                case (funct3)
                    3'd0: lsu_wr = MEM_WRITE_B;
                    3'd1: lsu_wr = MEM_WRITE_H;
                    3'd2: lsu_wr = MEM_WRITE_W;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm32   = imm_b(in_inst);
                case (funct3)
                    3'd0: alu_op = ALU_BEQ;
                    3'd1: alu_op = ALU_BNE;
                    3'd4: alu_op = ALU_BLT;
                    3'd5: alu_op = ALU_BGE;
                    3'd6: alu_op = ALU_BLTU;
                    3'd7: alu_op = ALU_BGEU;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_JAL: begin
                src1_pc = 1'b1;
                imm32   = imm_j(in_inst);
                ctrl[CTRL_JUMP]   = 1'b1;
                ctrl[CTRL_REG_WR] = 1'b1;
            end
            OPC_JALR: begin
                use_rs1 = 1'b1;
                imm32   = imm_i(in_inst);
                illegal = (funct3 != 3'd0);
                ctrl[CTRL_JALR]   = 1'b1;
                ctrl[CTRL_REG_WR] = 1'b1;
            end
            OPC_LUI: begin
                imm32 = imm_u(in_inst);
                ctrl[CTRL_REG_WR] = 1'b1;
            end
            OPC_AUIPC: begin
                src1_pc = 1'b1;
                imm32   = imm_u(in_inst);
                ctrl[CTRL_REG_WR] = 1'b1;
            end
            OPC_SYSTEM: begin
                case (funct3)
                    3'd0: begin
                        if (in_inst == INST_ECALL)       ctrl[CTRL_ECALL]  = 1'b1;
                        else if (in_inst == INST_EBREAK) ctrl[CTRL_EBREAK] = 1'b1;
                        else if (in_inst == INST_MRET)   ctrl[CTRL_MRET]   = 1'b1;
                        else                             illegal = 1'b1;
                    end
                    // CSR address travels zero-extended in imm; csrrs ORs rs1 into the CSR
                    3'd1, 3'd2: begin
                        use_rs1 = 1'b1;
                        imm32   = {20'b0, in_inst[31:20]};
                        alu_op  = (funct3 == 3'd2) ? ALU_OR : ALU_ADD;
                        ctrl[CTRL_CSR_WR] = 1'b1;
                        ctrl[CTRL_REG_WR] = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            ctrl    = '0;
            ctrl[CTRL_ILLEGAL] = 1'b1;
            lsu_rd  = NO_MEM_READ;
            lsu_wr  = NO_MEM_WRITE;
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
            src1_pc = 1'b0;
        end
    end

    ysyx_25040129_fwd_sel #(.XLEN(XLEN), .RA_W(RA_W), .NUM_FWD(NUM_FWD)) u_fwd_rs1 (
        .addr(rs1_addr), .rdata(rs1_rdata), .fwd_pend(fwd_pend), .fwd_rd(fwd_rd),
        .fwd_ok(fwd_ok), .fwd_data(fwd_data), .value(val1), .hazard(haz1)
    );

    ysyx_25040129_fwd_sel #(.XLEN(XLEN), .RA_W(RA_W), .NUM_FWD(NUM_FWD)) u_fwd_rs2 (
        .addr(rs2_addr), .rdata(rs2_rdata), .fwd_pend(fwd_pend), .fwd_rd(fwd_rd),
        .fwd_ok(fwd_ok), .fwd_data(fwd_data), .value(val2), .hazard(haz2)
    );

    // Hazards only count for an instruction that is actually offered and only
    // for the sources it reads, so an empty stage ignores fwd_* entirely.
    assign hazard   = in_valid && ((use_rs1 && haz1) || (use_rs2 && haz2));
    assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
    assign capture  = in_valid && in_ready;

    assign imm_x = XLEN'($signed(imm32));
    assign src1  = use_rs1 ? val1 : (src1_pc ? in_pc : '0);
    assign src2  = use_rs2 ? val2 : imm_x;

    // ID/EX register: flush beats capture, capture beats drain.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_pc     <= '0;
            out_src1   <= '0;
            out_src2   <= '0;
            out_imm    <= '0;
            out_rd     <= '0;
            out_alu_op <= '0;
            out_ctrl   <= '0;
            out_lsu_rd <= NO_MEM_READ;
            out_lsu_wr <= NO_MEM_WRITE;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid  <= 1'b1;
            out_pc     <= in_pc;
            out_src1   <= src1;
            out_src2   <= src2;
            out_imm    <= imm_x;
            out_rd     <= in_inst[7 +: RA_W];
            out_alu_op <= alu_op;
            out_ctrl   <= ctrl;
            out_lsu_rd <= lsu_rd;
            out_lsu_wr <= lsu_wr;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef YSYX_25040129_IDU_PERF_EN
    // Free-running counters that wrap naturally at 2^32
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_issue <= '0;
            perf_stall <= '0;
        end else begin
            if (capture)
                perf_issue <= perf_issue + 32'd1;
            if (in_valid && hazard && !flush)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`else
    // Without the perf option the stage has no counters.
`endif

endmodule

// File: doc/ysyx_25040129_idu_stage.md
# ysyx_25040129_idu_stage

Parametrised, registered decode stage for the ysyx_25040129 in-order RV32E/Zicsr pipeline, sitting between IFU and EXU. It decodes the instruction and reads the register file. Source operands are resolved through NUM_FWD generic forwarding ports, searched in priority order; the stage stalls on unresolved RAW hazards. The decoded bundle is held in an ID/EX output register with valid/ready handshake and flush.

## Interface
Parameters:
- XLEN, 32, datapath width
- RA_W, 4, register-address width (16 GPRs)
- NUM_FWD, 3, forwarding/hazard ports; index 0 = youngest (EXU), highest priority

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  IFU offers instruction
- in_ready  out  1  stage accepts this cycle
- in_inst  in  32  instruction
- in_pc  in  XLEN  instruction PC
- rs1_addr, rs2_addr  out  RA_W  GPR read addresses = inst[15+:RA_W], inst[20+:RA_W]
- rs1_rdata, rs2_rdata  in  XLEN  GPR read data, same cycle
- fwd_pend  in  NUM_FWD  stage i holds a pending GPR write
- fwd_rd  in  NUM_FWD*RA_W  destination of stage i
- fwd_ok  in  NUM_FWD  stage i result available
- fwd_data  in  NUM_FWD*XLEN  result of stage i
- flush  in  1  redirect: kill held and incoming instruction
- out_valid  out  1  bundle valid to EXU
- out_ready  in  1  EXU accepts
- out_pc, out_src1, out_src2, out_imm  out  XLEN  decoded operands
- out_rd  out  RA_W  destination register
- out_alu_op  out  4  ALU opcode, same encoding as existing ALU
- out_ctrl  out  8  {illegal, ebreak, ecall, mret, jalr, jump, csr_wr, reg_wr}
- out_lsu_rd  out  3  / out_lsu_wr  out  2  LSU codes, NO_MEM_* when unused

## Operation
- Decode is combinational on in_inst. Same classes as current decode: OP-IMM, OP, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM (ecall/ebreak/mret/csrrw/csrrs).
- Unknown opcode/funct3: illegal=1, reg_wr=0, no LSU op; the instruction still flows to the output (never dropped).
- Operand use: src1 used by OP-IMM/OP/LOAD/STORE/BRANCH/JALR/CSR. src2 used by OP/STORE/BRANCH.
- Resolution per used source s, addr≠0: search i=0..NUM_FWD-1 for the first i with fwd_pend[i] && fwd_rd[i]==addr.
  - If found and fwd_ok[i]: value = fwd_data[i].
  - If found and !fwd_ok[i]: hazard.
  - If none: value = rsN_rdata.
  - Only the first match counts; older matches are ignored.
- Register x0 is never forwarded and never causes a hazard; its value is 0.
- Handshake: in_ready = (!out_valid || out_ready) && !hazard && !flush. Capture happens when in_valid && in_ready.
- Output register update each cycle:
  - flush: out_valid←0.
  - else capture: load bundle, out_valid←1.
  - else out_ready: out_valid←0.
  - else hold.
- While out_valid && !out_ready, all out_* hold stable.
- STORE: out_src2 = resolved rs2 (store data); out_imm = S-imm. The EXU adds src1+imm.

## Timing
- Latency: 1 cycle, IFU accept → out_valid.
- Throughput: 1 instruction/cycle when out_ready=1 and no hazard.
- Reset: out_valid=0; all out_* data = 0; out_lsu_rd=NO_MEM_READ; out_lsu_wr=NO_MEM_WRITE.
- Simultaneous flush + capture: flush wins; nothing loaded.
- Flush while stalled: cleared next cycle; the IFU re-presents the instruction after redirect.
- Hazard clears the same cycle fwd_ok rises; the instruction is accepted that cycle.
- Reset mid-stall: stage returns to empty and ignores all fwd_* until in_valid.

## Configuration
- YSYX_25040129_IDU_PERF_EN defined: adds outputs perf_issue (32b) and perf_stall (32b).
  - perf_issue increments on each capture.
  - perf_stall increments each cycle with in_valid && hazard && !flush.
  - Both wrap at 2^32 and reset to 0.
- Undefined: ports and counters absent; no other behaviour change.

## Structure
- Shared package/defines: opcode constants, ALU opcode encodings, MEM_READ_*/MEM_WRITE_*, out_ctrl bit indices.
- Sub-module ysyx_25040129_fwd_sel (per source, instantiated twice): inputs addr and fwd vectors; outputs value and hazard; priority encoder over NUM_FWD.

## Test plan
- ADDI x1,x0,5 with out_ready=1 → next cycle out_valid=1, src1=0, src2=5, reg_wr=1, alu_op=ADD.
- ADD x3,x1,x2, fwd_pend[0]=1, fwd_rd[0]=1, fwd_ok[0]=1, fwd_data[0]=0xA → src1=0xA, no stall.
- Same with fwd_ok[0]=0 for 3 cycles, while fwd_pend[2] also matches with ok=1 → in_ready=0 for 3 cycles, then src1=fwd_data[0].
- out_ready=0 for 4 cycles with a valid bundle → outputs stable and in_ready=0; on release, back-to-back capture.
- flush asserted with in_valid=1 and out_valid=1 → out_valid=0 next cycle; no capture.
- Opcode 0x7F → out_ctrl illegal=1, reg_wr=0; under PERF_EN, perf_issue increments by 1.
